linear_4b_dequantizer: RTL and testbench

- Expands a stream of packed 4-bit linear-space grey indices back to 8-bit linear values, one pixel per clock.
- Inverse of the 4-bit linear quantizer.
- Sits between the packed framebuffer read path and the waveform/LUT lookup stage.
- Unpacks PIX_PER_WORD indices per input word, uses ready/valid on both sides, and flags end-of-line.

---
 rtl/caster_pkg.sv | 13 +
 rtl/linear_4b_expand.sv | 11 +
 rtl/linear_4b_dequantizer.sv | 112 +++++++++++
 tb/tb_linear_4b_dequantizer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/caster_pkg.sv
// Shared grey-level constants for the 4-bit linear quantizer / dequantizer pair.
package caster_pkg;

  localparam int IDX_W = 4;
  localparam int LIN_W = 8;

  // Index -> 8-bit linear value; the quantizer's decision table mirrors this one.
  localparam logic [LIN_W-1:0] LINEAR4_LUT [16] = '{
    8'd0,   8'd1,   8'd3,   8'd7,   8'd13,  8'd22,  8'd33,  8'd47,
    8'd63,  8'd82,  8'd104, 8'd128, 8'd156, 8'd186, 8'd219, 8'd255
  };

endpackage

// File: rtl/linear_4b_expand.sv
// Pure combinational 4-bit grey index to 8-bit linear value lookup.
module linear_4b_expand
  import caster_pkg::*;
(
  input  logic [IDX_W-1:0] i_index,
  output logic [LIN_W-1:0] o_linear
);

  assign o_linear = LINEAR4_LUT[i_index];

endmodule

// File: rtl/linear_4b_dequantizer.sv
// Unpacks packed 4-bit grey indices one pixel per clock and expands them to linear values,
// with ready/valid on both sides and an end-of-line flag from a pixel counter.
module linear_4b_dequantizer
  import caster_pkg::*;
#(
  parameter int PIX_PER_WORD = 4,
  parameter int H_PIXELS     = 1600
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [IDX_W*PIX_PER_WORD-1:0]   s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [IDX_W-1:0]                m_index,
  output logic [LIN_W-1:0]                m_linear,
  output logic                            m_eol
);

  localparam int LANE_W = $clog2(PIX_PER_WORD);
  localparam int PIX_W  = $clog2(H_PIXELS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(H_PIXELS - 1);

  logic                          r_run;
  logic                          r_buf_vld;
  logic [LANE_W-1:0]             r_lane;
  logic [IDX_W*PIX_PER_WORD-1:0] r_buf;
  logic [PIX_W-1:0]              r_pix;
  logic                          r_m_valid;
  logic [IDX_W-1:0]              r_index;
  logic [LIN_W-1:0]              r_linear;
  logic                          r_eol;

  logic                          w_xfer;
  logic                          w_load;
  logic                          w_last;
  logic                          w_accept;
  logic [IDX_W-1:0]              w_lane_idx;
  logic [LIN_W-1:0]              w_lane_lin;
  logic [PIX_W-1:0]              w_pix_nxt;

  assign w_xfer   = r_m_valid && m_ready;
  assign w_load   = r_buf_vld && (!r_m_valid || m_ready);
  assign w_last   = (r_lane == LAST_LANE);
  // A new word may land in the same edge that issues the buffer's last lane.
  assign s_ready  = r_run && !flush && (!r_buf_vld || (w_last && w_load));
  assign w_accept = s_valid && s_ready;

  assign w_lane_idx = r_buf[int'(r_lane)*IDX_W +: IDX_W];

  linear_4b_expand u_expand (
    .i_index  (w_lane_idx),
    .o_linear (w_lane_lin)
  );

  // Position of the pixel sitting in the output register after this edge.
  assign w_pix_nxt = w_xfer ? ((r_pix == LAST_PIX) ? '0 : r_pix + 1'b1) : r_pix;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run     <= 1'b0;
      r_buf_vld <= 1'b0;
      r_lane    <= '0;
      r_pix     <= '0;
      r_m_valid <= 1'b0;
      r_index   <= '0;
      r_linear  <= '0;
      r_eol     <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_buf_vld <= 1'b0;
        r_lane    <= '0;
        r_pix     <= '0;
        r_m_valid <= 1'b0;
      end else begin
        r_pix <= w_pix_nxt;

        if (w_accept) begin
          r_buf_vld <= 1'b1;
          r_lane    <= '0;
        end else if (w_load) begin
          if (w_last) r_buf_vld <= 1'b0;
          else        r_lane    <= r_lane + 1'b1;
        end

        if (w_load) begin
          r_m_valid <= 1'b1;
          r_index   <= w_lane_idx;
          r_linear  <= w_lane_lin;
          r_eol     <= (w_pix_nxt == LAST_PIX);
        end else if (w_xfer) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  end

  // Word payload is qualified by r_buf_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) r_buf <= s_data;
  end

  assign m_valid  = r_m_valid;
  assign m_index  = r_index;
  assign m_linear = r_linear;
  assign m_eol    = r_eol;

endmodule

// File: tb/tb_linear_4b_dequantizer.sv
// Directed and randomized bench for linear_4b_dequantizer (4 lanes per word, 8-pixel lines).
module tb_linear_4b_dequantizer;

  localparam int P  = 4;
  localparam int H  = 8;
  localparam int NW = 1500;

  logic        clk = 1'b0;
  logic        rstn, flush, s_valid, s_ready, m_valid, m_ready, m_eol;
  logic [15:0] s_data;
  logic [3:0]  m_index;
  logic [7:0]  m_linear;

  always #5 clk = ~clk;

  linear_4b_dequantizer #(.PIX_PER_WORD(P), .H_PIXELS(H)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_index  (m_index),
    .m_linear (m_linear),
    .m_eol    (m_eol)
  );

  logic [7:0] exp_lin [16] = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd13, 8'd22, 8'd33, 8'd47,
                               8'd63, 8'd82, 8'd104, 8'd128, 8'd156, 8'd186, 8'd219, 8'd255};

  typedef struct {
    logic [3:0] idx;
    logic [7:0] lin;
    logic       eol;
    int         cyc;
  } pix_t;

  pix_t        got[$];
  logic [15:0] wq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          first_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Push words from wq with m_ready=1, recording every output transfer.
  task automatic stream(input int n_pix, input int max_cyc);
    int wp;
    wp = 0;
    first_acc = -1;
    got.delete();
    for (int c = 0; c < max_cyc && got.size() < n_pix; c++) begin
      m_ready = 1'b1;
      if (m_valid && m_ready)
        got.push_back('{idx: m_index, lin: m_linear, eol: m_eol, cyc: cyc});
      s_valid = (wp < wq.size());
      s_data  = s_valid ? wq[wp] : 16'h0;
      #1;
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc + 1;
        wp++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("stream_count", got.size(), n_pix);
  endtask

  initial begin
    int vcount;
    logic [15:0] cur;
    bit          have;
    int          sent, popped, pc;
    logic [3:0]  e;
    logic [3:0]  expq[$];

    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_index",  m_index,  0);
    check("rst_m_linear", m_linear, 0);
    check("rst_m_eol",    m_eol,    0);
    check("rst_s_ready",  s_ready,  0);
    rstn = 1'b1;
    tick();
    check("post_rst_s_ready", s_ready, 1);

    // Lookup sweep, also covers end-of-line at pixels 7 and 15
    wq = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    stream(16, 100);
    for (int k = 0; k < 16; k++) begin
      if (k < got.size()) begin
        check($sformatf("sweep_idx%0d", k), got[k].idx, k);
        check($sformatf("sweep_lin%0d", k), got[k].lin, exp_lin[k]);
        check($sformatf("sweep_eol%0d", k), got[k].eol, (k == 7 || k == 15));
      end
    end
    if (got.size() == 16) begin
      check("sweep_latency", got[0].cyc, first_acc + 1);
      check("sweep_no_gap", got[15].cyc, got[0].cyc + 15);
    end
    tick();
    check("sweep_idle_valid", m_valid, 0);

    // Backpressure
    s_valid = 1'b1; s_data = 16'hF0A5; m_ready = 1'b1;
    #1;
    check("bp_s_ready_idle", s_ready, 1);
    tick();
    s_valid = 1'b0;
    tick();
    check("bp_first_valid", m_valid, 1);
    check("bp_first_idx", m_index, 5);
    for (int i = 0; i < 3; i++) begin
      m_ready = 1'b0;
      #1;
      check($sformatf("bp_s_ready_%0d", i), s_ready, 0);
      tick();
      check($sformatf("bp_hold_valid_%0d", i), m_valid, 1);
      check($sformatf("bp_hold_idx_%0d", i), m_index, 5);
      check($sformatf("bp_hold_lin_%0d", i), m_linear, 22);
    end
    wq.delete();
    stream(4, 20);
    if (got.size() == 4) begin
      check("bp_idx0", got[0].idx, 5);   check("bp_lin0", got[0].lin, 22);
      check("bp_idx1", got[1].idx, 10);  check("bp_lin1", got[1].lin, 104);
      check("bp_idx2", got[2].idx, 0);   check("bp_lin2", got[2].lin, 0);
      check("bp_idx3", got[3].idx, 15);  check("bp_lin3", got[3].lin, 255);
      check("bp_eol", {got[0].eol, got[1].eol, got[2].eol, got[3].eol}, 0);
    end

    // Flush mid-word
    s_valid = 1'b1; s_data = 16'h4321;
    #1;
    check("fl_accept", s_ready, 1);
    tick();
    s_valid = 1'b0;
    tick();
    check("fl_pix1", m_index, 1);
    tick();
    check("fl_pix2", m_index, 2);
    flush = 1'b1; s_valid = 1'b1; s_data = 16'h8888;
    #1;
    check("fl_s_ready", s_ready, 0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("fl_m_valid", m_valid, 0);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_valid) vcount++;
    end
    check("fl_dropped", vcount, 0);
    wq = '{16'h0000, 16'h0000};
    stream(8, 40);
    for (int k = 0; k < 8; k++)
      if (k < got.size())
        check($sformatf("fl_after_%0d", k), {got[k].idx, got[k].eol}, {4'd0, (k == 7)});

    // Asynchronous reset mid-word
    s_valid = 1'b1; s_data = 16'hCCCC;
    tick();
    s_valid = 1'b0;
    tick();
    check("ar_pre_valid", m_valid, 1);
    check("ar_pre_lin", m_linear, 156);
    #2 rstn = 1'b0;
    #1;
    check("ar_m_valid",  m_valid,  0);
    check("ar_m_index",  m_index,  0);
    check("ar_m_linear", m_linear, 0);
    check("ar_m_eol",    m_eol,    0);
    #1 rstn = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_valid) vcount++;
    end
    check("ar_no_stale", vcount, 0);
    check("ar_s_ready", s_ready, 1);
    wq = '{16'h3210};
    stream(4, 20);
    for (int k = 0; k < 4; k++)
      if (k < got.size())
        check($sformatf("ar_after_%0d", k), {got[k].idx, got[k].eol}, {4'(k), 1'b0});

    // Random stress against a scoreboard
    flush = 1'b1;
    tick();
    flush = 1'b0;
    have = 0; sent = 0; popped = 0; pc = 0; cur = '0;
    for (int c = 0; c < 60000; c++) begin
      if (sent == NW && !have && expq.size() == 0 && !m_valid) break;
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          check("stress_extra_pixel", 1, 0);
        end else begin
          e = expq.pop_front();
          check("stress_pix", {m_index, m_linear, m_eol}, {e, exp_lin[e], (pc == H - 1)});
          pc = (pc + 1) % H;
          popped++;
        end
      end
      if (!have && sent < NW && $urandom_range(0, 1) == 1) begin
        cur  = 16'($urandom);
        have = 1;
      end
      s_valid = have;
      s_data  = cur;
      #1;
      if (s_valid && s_ready) begin
        for (int k = 0; k < P; k++) expq.push_back(cur[4*k +: 4]);
        have = 0;
        sent++;
      end
      tick();
    end
    s_valid = 1'b0;
    check("stress_words", sent, NW);
    check("stress_pixels", popped, NW * P);
    check("stress_leftover", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
